// File: rtl/instruction_encoder.sv
// Encodes symbolic LEGv8 requests into 32-bit words and writes them sequentially to instruction memory.
// One request is accepted per IDLE cycle; each word is held on the write port until mem_ack.
module instruction_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [1:0]        hw,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_inc;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic                r_err;
  logic                r_full;
  logic [31:0]         w_enc;
  logic                w_legal;

  // Every legal word carries a unique opcode pattern in [31:21]; unused fields stay zero.
  always_comb begin
    w_enc   = 32'd0;
    w_legal = 1'b1;
    case (op)
      4'd0:    w_enc = {11'b10001010000, rm, 6'b000000, rn, rd};
      4'd1:    w_enc = {11'b10101010000, rm, 6'b000000, rn, rd};
      4'd2:    w_enc = {11'b10001011000, rm, 6'b000000, rn, rd};
      4'd3:    w_enc = {11'b11001011000, rm, 6'b000000, rn, rd};
      4'd4:    w_enc = {10'b1001000100, imm[11:0], rn, rd};
      4'd5:    w_enc = {10'b1101000100, imm[11:0], rn, rd};
      4'd6:    w_enc = {9'b110100101, hw, imm[15:0], rd};
      4'd7:    w_enc = {6'b000101, imm[25:0]};
      4'd8:    w_enc = {8'b10110100, imm[18:0], rd};
      4'd9:    w_enc = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      4'd10:   w_enc = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid && w_legal) w_state_next = WRITE;
      WRITE:   if (mem_ack) w_state_next = (w_count_inc == LP_DEPTH) ? FULL : IDLE;
      FULL:    w_state_next = FULL;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (clear) begin
        // clear beats a same-cycle ack: the aborted word is never counted
        r_ptr   <= '0;
        r_count <= '0;
        r_we    <= 1'b0;
        r_full  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid) begin
              if (w_legal) begin
                r_wdata <= w_enc;
                r_we    <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (mem_ack) begin
              r_we    <= 1'b0;
              r_ptr   <= r_ptr + 1'b1;
              r_count <= w_count_inc;
              if (w_count_inc == LP_DEPTH) r_full <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Ready follows state only; held low while Reset is asserted.
  assign in_ready   = (r_state == IDLE) && !Reset;
  assign mem_we     = r_we;
  assign mem_addr   = r_ptr;
  assign mem_wdata  = r_wdata;
  assign err        = r_err;
  assign full       = r_full;
  assign word_count = r_count;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a depth-64 instance for encodings/flow and a depth-4 instance for FULL.
module tb_instruction_encoder;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  rd = '0, rn = '0, rm = '0;
  logic [25:0] imm = '0;
  logic [1:0]  hw = '0;

  logic        b_valid = 1'b0, b_ack = 1'b0;
  logic        b_ready, b_we, b_err, b_full;
  logic [5:0]  b_addr;
  logic [31:0] b_wdata;
  logic [6:0]  b_count;

  logic        s_valid = 1'b0, s_ack = 1'b0;
  logic        s_ready, s_we, s_err, s_full;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] saved_count;

  always #5 CLK = ~CLK;

  instruction_encoder #(.ADDR_W(6)) u_big (
    .CLK(CLK), .Reset(Reset), .clear(clear), .in_valid(b_valid), .in_ready(b_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_ack(b_ack),
    .err(b_err), .full(b_full), .word_count(b_count)
  );

  instruction_encoder #(.ADDR_W(2)) u_small (
    .CLK(CLK), .Reset(Reset), .clear(clear), .in_valid(s_valid), .in_ready(s_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_ack(s_ack),
    .err(s_err), .full(s_full), .word_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fields(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                        input logic [4:0] m, input logic [25:0] i, input logic [1:0] h);
    op = o; rd = d; rn = n; rm = m; imm = i; hw = h;
  endtask

  // Present one request to the big instance for one edge, then check the held write.
  task automatic b_req(input string tag, input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [25:0] i, input logic [1:0] h,
                       input logic [31:0] exp_word, input logic [5:0] exp_addr);
    fields(o, d, n, m, i, h);
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk({tag, " we"}, {31'd0, b_we}, 32'd1);
    chk({tag, " wdata"}, b_wdata, exp_word);
    chk({tag, " addr"}, {26'd0, b_addr}, {26'd0, exp_addr});
    chk({tag, " ready"}, {31'd0, b_ready}, 32'd0);
  endtask

  task automatic b_do_ack(input string tag, input logic [6:0] exp_count);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk({tag, " we_after_ack"}, {31'd0, b_we}, 32'd0);
    chk({tag, " count"}, {25'd0, b_count}, {25'd0, exp_count});
    chk({tag, " ready_after_ack"}, {31'd0, b_ready}, 32'd1);
  endtask

  task automatic s_write(input string tag, input logic [1:0] exp_addr);
    fields(4'd2, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk({tag, " we"}, {31'd0, s_we}, 32'd1);
    chk({tag, " addr"}, {30'd0, s_addr}, {30'd0, exp_addr});
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst ready_in_reset", {31'd0, b_ready}, 32'd0);
    chk("rst we", {31'd0, b_we}, 32'd0);
    chk("rst wdata", b_wdata, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rst ready", {31'd0, b_ready}, 32'd1);
    chk("rst addr", {26'd0, b_addr}, 32'd0);
    chk("rst err", {31'd0, b_err}, 32'd0);
    chk("rst full", {31'd0, b_full}, 32'd0);
    chk("rst count", {25'd0, b_count}, 32'd0);

    // First transaction
    b_req("add", 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023, 6'd0);
    b_do_ack("add", 7'd1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr count", {25'd0, b_count}, 32'd0);
    chk("clr addr", {26'd0, b_addr}, 32'd0);

    // Stream with a held-off acknowledge on the second word
    b_req("addi", 4'd4, 5'd9, 5'd9, 5'd0, 26'd1, 2'd0, 32'h91000529, 6'd0);
    b_do_ack("addi", 7'd1);
    b_req("movz", 4'd6, 5'd5, 5'd0, 5'd0, 26'h1234, 2'd1, 32'hD2A24685, 6'd1);
    fields(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold wdata", b_wdata, 32'hD2A24685);
      chk("hold addr", {26'd0, b_addr}, 32'd1);
      chk("hold ready", {31'd0, b_ready}, 32'd0);
      chk("hold we", {31'd0, b_we}, 32'd1);
    end
    b_do_ack("movz", 7'd2);
    b_req("ldur", 4'd9, 5'd2, 5'd10, 5'd0, 26'd8, 2'd0, 32'hF8408142, 6'd2);
    b_do_ack("ldur", 7'd3);

    // Immediate truncation and remaining formats
    b_req("cbz", 4'd8, 5'd7, 5'd0, 5'd0, 26'h7FFFE, 2'd0, 32'hB4FFFFC7, 6'd3);
    b_do_ack("cbz", 7'd4);
    b_req("b", 4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 32'h17FFFFFF, 6'd4);
    b_do_ack("b", 7'd5);
    b_req("addi_trunc", 4'd4, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF, 2'd0, 32'h913FFC41, 6'd5);
    b_do_ack("addi_trunc", 7'd6);
    b_req("stur", 4'd10, 5'd1, 5'd2, 5'd0, 26'h1FF, 2'd0, 32'hF81FF041, 6'd6);
    b_do_ack("stur", 7'd7);
    b_req("sub", 4'd3, 5'd31, 5'd31, 5'd31, 26'd0, 2'd0, 32'hCB1F03FF, 6'd7);
    b_do_ack("sub", 7'd8);
    b_req("subi", 4'd5, 5'd1, 5'd2, 5'd0, 26'd4, 2'd0, 32'hD1001041, 6'd8);
    b_do_ack("subi", 7'd9);
    b_req("and", 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 32'h8A000000, 6'd9);
    b_do_ack("and", 7'd10);
    b_req("orr", 4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 32'hAA0600A4, 6'd10);
    b_do_ack("orr", 7'd11);

    // Illegal op is dropped with a single err pulse
    saved_count = b_count;
    fields(4'd12, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0);
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("ill err", {31'd0, b_err}, 32'd1);
    chk("ill we", {31'd0, b_we}, 32'd0);
    chk("ill ready", {31'd0, b_ready}, 32'd1);
    tick();
    chk("ill err_pulse", {31'd0, b_err}, 32'd0);
    chk("ill count", {25'd0, b_count}, {25'd0, saved_count});
    b_req("post_ill", 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023, 6'd11);
    b_do_ack("post_ill", 7'd12);

    // Depth-4 instance fills up
    s_write("s0", 2'd0);
    s_write("s1", 2'd1);
    s_write("s2", 2'd2);
    chk("s pre_full", {31'd0, s_full}, 32'd0);
    s_write("s3", 2'd3);
    chk("s full", {31'd0, s_full}, 32'd1);
    chk("s ready_full", {31'd0, s_ready}, 32'd0);
    chk("s count_full", {29'd0, s_count}, 32'd4);
    chk("s addr_wrap", {30'd0, s_addr}, 32'd0);
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    chk("s ignored_we", {31'd0, s_we}, 32'd0);
    chk("s still_full", {31'd0, s_full}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("s clr_count", {29'd0, s_count}, 32'd0);
    chk("s clr_full", {31'd0, s_full}, 32'd0);
    chk("s clr_ready", {31'd0, s_ready}, 32'd1);
    s_write("s_after_clr", 2'd0);
    chk("s count_after_clr", {29'd0, s_count}, 32'd1);

    // clear racing mem_ack mid-write
    b_req("race", 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023, 6'd0);
    b_ack = 1'b1;
    clear = 1'b1;
    tick();
    b_ack = 1'b0;
    clear = 1'b0;
    chk("race we", {31'd0, b_we}, 32'd0);
    chk("race count", {25'd0, b_count}, 32'd0);
    chk("race addr", {26'd0, b_addr}, 32'd0);
    chk("race ready", {31'd0, b_ready}, 32'd1);

    // clear together with in_valid in IDLE is not an accept
    fields(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0);
    b_valid = 1'b1;
    clear = 1'b1;
    tick();
    b_valid = 1'b0;
    clear = 1'b0;
    chk("clr_valid we", {31'd0, b_we}, 32'd0);

    // Reset mid-write
    b_req("rst_mid", 4'd6, 5'd5, 5'd0, 5'd0, 26'h1234, 2'd1, 32'hD2A24685, 6'd0);
    Reset = 1'b1;
    tick();
    chk("rmid we", {31'd0, b_we}, 32'd0);
    chk("rmid addr", {26'd0, b_addr}, 32'd0);
    chk("rmid wdata", b_wdata, 32'd0);
    chk("rmid err", {31'd0, b_err}, 32'd0);
    chk("rmid full", {31'd0, b_full}, 32'd0);
    chk("rmid count", {25'd0, b_count}, 32'd0);
    chk("rmid ready", {31'd0, b_ready}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rmid ready_after", {31'd0, b_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
